// File: rtl/adsb_pkg.sv
// rtl/adsb_pkg.sv - shared constants, config record and demodulator state type
package adsb_pkg;

    localparam logic [15:0] ADSB_MAGIC      = 16'hAD5B;
    localparam logic [7:0]  ADSB_MODULE_ID  = 8'h01;
    localparam logic [7:0]  ADSB_MSG_CONFIG = 8'h01;
    localparam logic [7:0]  ADSB_MSG_REPORT = 8'h02;

    localparam int ADSB_CONFIG_WIDTH = 64;
    localparam int ADSB_PREAMBLE_LEN = 16;
    localparam int ADSB_MSG_BITS     = 112;
    localparam int ADSB_REPORT_WORDS = 6;

    localparam logic [31:0] ADSB_CONFIG_HDR = {ADSB_MAGIC, ADSB_MODULE_ID, ADSB_MSG_CONFIG};
    localparam logic [31:0] ADSB_REPORT_HDR = {ADSB_MAGIC, ADSB_MODULE_ID, ADSB_MSG_REPORT};

    typedef struct packed {
        logic [15:0] threshold;
    } adsb_config_t;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DATA
    } adsb_state_t;

endpackage

// File: rtl/adsb_preamble_detector.sv
// rtl/adsb_preamble_detector.sv - 16-tap magnitude window with PPM preamble compare
module adsb_preamble_detector
    import adsb_pkg::*;
#(
    parameter int MAG_WIDTH = 15
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Mag_valid,
    input  logic [MAG_WIDTH-1:0] Mag,
    input  logic                 Enable,
    input  logic [15:0]          Threshold,
    output logic                 Detect
);

    localparam int CW = (MAG_WIDTH > 16) ? MAG_WIDTH : 16;

    logic [MAG_WIDTH-1:0] win [ADSB_PREAMBLE_LEN];
    logic [MAG_WIDTH-1:0] nxt [ADSB_PREAMBLE_LEN];
    logic [MAG_WIDTH-1:0] pulse_min;
    logic [MAG_WIDTH-1:0] gap_max;

    // Compare against the window as it will be after this sample shifts in,
    // so the detect lines up with the last preamble sample and the first
    // data sample is never missed.
    always_comb begin
        for (int i = 0; i < ADSB_PREAMBLE_LEN - 1; i++) begin
            nxt[i] = win[i+1];
        end
        nxt[ADSB_PREAMBLE_LEN-1] = Mag;

        pulse_min = nxt[0];
        if (nxt[2] < pulse_min) pulse_min = nxt[2];
        if (nxt[7] < pulse_min) pulse_min = nxt[7];
        if (nxt[9] < pulse_min) pulse_min = nxt[9];

        gap_max = nxt[1];
        if (nxt[3] > gap_max) gap_max = nxt[3];
        if (nxt[4] > gap_max) gap_max = nxt[4];
        if (nxt[5] > gap_max) gap_max = nxt[5];
        if (nxt[6] > gap_max) gap_max = nxt[6];
        if (nxt[8] > gap_max) gap_max = nxt[8];
    end

    assign Detect = Mag_valid && Enable && (Threshold != 16'd0)
                 && (CW'(pulse_min) >= CW'(Threshold))
                 && (pulse_min > gap_max);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < ADSB_PREAMBLE_LEN; i++) begin
                win[i] <= '0;
            end
        end else if (Mag_valid) begin
            for (int i = 0; i < ADSB_PREAMBLE_LEN; i++) begin
                win[i] <= nxt[i];
            end
        end
    end

endmodule

// File: rtl/adsb_demodulator.sv
// rtl/adsb_demodulator.sv - ADS-B PPM demodulator with stream config and report frames
module adsb_demodulator
    import adsb_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int IQ_WIDTH       = 14
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       Adc_valid,
    input  logic signed [IQ_WIDTH-1:0] Adc_data_i,
    input  logic signed [IQ_WIDTH-1:0] Adc_data_q,
    output logic                       S_axis_ready,
    input  logic                       S_axis_valid,
    input  logic [AXI_DATA_WIDTH-1:0]  S_axis_data,
    input  logic                       S_axis_last,
    input  logic                       M_axis_ready,
    output logic                       M_axis_valid,
    output logic [AXI_DATA_WIDTH-1:0]  M_axis_data,
    output logic                       M_axis_last
);

    localparam int MW       = IQ_WIDTH + 1;
    localparam int LAST_SMP = 2 * ADSB_MSG_BITS - 1;

    typedef enum logic [1:0] {
        CFG_HDR,
        CFG_BODY,
        CFG_SKIP
    } cfg_state_t;

    function automatic logic [MW-1:0] abs_iq(input logic signed [IQ_WIDTH-1:0] x);
        logic signed [MW-1:0] e;
        e = {x[IQ_WIDTH-1], x};
        if (e[MW-1]) e = -e;
        return e;
    endfunction

    function automatic logic [31:0] report_word(input logic [2:0] idx, input logic [31:0] ts,
                                               input logic [ADSB_MSG_BITS-1:0] msg);
        case (idx)
            3'd0:    return ADSB_REPORT_HDR;
            3'd1:    return ts;
            3'd2:    return msg[111:80];
            3'd3:    return msg[79:48];
            3'd4:    return msg[47:16];
            default: return {msg[15:0], 16'h0000};
        endcase
    endfunction

    adsb_config_t              cfg;
    cfg_state_t                cfg_state;
    adsb_state_t               state;
    logic [MW-1:0]             mag;
    logic                      mag_valid;
    logic [31:0]               timestamp;
    logic [31:0]               mag_ts;
    logic                      detect;
    logic [7:0]                samp_cnt;
    logic [MW-1:0]             first_mag;
    logic [ADSB_MSG_BITS-1:0]  shreg;
    logic [31:0]               det_ts;
    logic                      msg_done;
    logic [ADSB_MSG_BITS-1:0]  msg_full;
    logic [2:0]                rep_idx;
    logic [31:0]               rep_ts;
    logic [ADSB_MSG_BITS-1:0]  rep_msg;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mag       <= '0;
            mag_valid <= 1'b0;
            mag_ts    <= '0;
            timestamp <= '0;
        end else begin
            mag_valid <= Adc_valid;
            if (Adc_valid) begin
                mag       <= abs_iq(Adc_data_i) + abs_iq(Adc_data_q);
                mag_ts    <= timestamp;
                timestamp <= timestamp + 32'd1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            S_axis_ready <= 1'b0;
            cfg_state    <= CFG_HDR;
            cfg          <= '0;
        end else begin
            S_axis_ready <= 1'b1;
            if (S_axis_valid && S_axis_ready) begin
                case (cfg_state)
                    CFG_HDR: begin
                        if (!S_axis_last)
                            cfg_state <= (S_axis_data == ADSB_CONFIG_HDR) ? CFG_BODY : CFG_SKIP;
                    end
                    CFG_BODY: begin
                        cfg.threshold <= S_axis_data[15:0];
                        cfg_state     <= S_axis_last ? CFG_HDR : CFG_SKIP;
                    end
                    default: begin
                        if (S_axis_last) cfg_state <= CFG_HDR;
                    end
                endcase
            end
        end
    end

    adsb_preamble_detector #(
        .MAG_WIDTH (MW)
    ) u_preamble (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Mag_valid (mag_valid),
        .Mag       (mag),
        .Enable    (state == SEARCH),
        .Threshold (cfg.threshold),
        .Detect    (detect)
    );

    assign msg_done = (state == DATA) && mag_valid && (samp_cnt == 8'(LAST_SMP));
    assign msg_full = {shreg[ADSB_MSG_BITS-2:0], (first_mag > mag)};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            samp_cnt  <= '0;
            first_mag <= '0;
            shreg     <= '0;
            det_ts    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg.threshold != 16'd0) state <= SEARCH;
                end
                SEARCH: begin
                    if (cfg.threshold == 16'd0) begin
                        state <= IDLE;
                    end else if (detect) begin
                        det_ts   <= mag_ts - 32'(ADSB_PREAMBLE_LEN - 1);
                        samp_cnt <= '0;
                        state    <= DATA;
                    end
                end
                default: begin
                    if (mag_valid) begin
                        samp_cnt <= samp_cnt + 8'd1;
                        if (!samp_cnt[0]) first_mag <= mag;
                        else              shreg     <= msg_full;
                        if (msg_done) state <= (cfg.threshold != 16'd0) ? SEARCH : IDLE;
                    end
                end
            endcase
        end
    end

    // Single-entry report buffer: a message finishing while it is occupied is lost.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            M_axis_valid <= 1'b0;
            M_axis_data  <= '0;
            M_axis_last  <= 1'b0;
            rep_idx      <= '0;
            rep_ts       <= '0;
            rep_msg      <= '0;
        end else if (!M_axis_valid) begin
            if (msg_done) begin
                rep_msg      <= msg_full;
                rep_ts       <= det_ts;
                rep_idx      <= '0;
                M_axis_valid <= 1'b1;
                M_axis_data  <= ADSB_REPORT_HDR;
                M_axis_last  <= 1'b0;
            end
        end else if (M_axis_ready) begin
            if (rep_idx == 3'(ADSB_REPORT_WORDS - 1)) begin
                M_axis_valid <= 1'b0;
                M_axis_data  <= '0;
                M_axis_last  <= 1'b0;
            end else begin
                rep_idx     <= rep_idx + 3'd1;
                M_axis_data <= report_word(rep_idx + 3'd1, rep_ts, rep_msg);
                M_axis_last <= (rep_idx == 3'(ADSB_REPORT_WORDS - 2));
            end
        end
    end

endmodule

// File: tb/tb_adsb_demodulator.sv
// tb/tb_adsb_demodulator.sv - scoreboard bench for adsb_demodulator
module tb_adsb_demodulator;

    logic               Clk = 1'b0;
    logic               Rst_n;
    logic               Adc_valid;
    logic signed [13:0] Adc_data_i;
    logic signed [13:0] Adc_data_q;
    logic               S_axis_ready;
    logic               S_axis_valid;
    logic [31:0]        S_axis_data;
    logic               S_axis_last;
    logic               M_axis_ready;
    logic               M_axis_valid;
    logic [31:0]        M_axis_data;
    logic               M_axis_last;

    int          n_cmp = 0;
    int          n_err = 0;
    int          sample_cnt = 0;
    logic [32:0] sb[$];

    logic [111:0] msg_a = 112'h8D4840D6202CC371C32CE0576098;
    logic [111:0] msg_b = 112'h5D3C6614A1B2C3D4E5F60718293A;

    logic        prev_v, prev_r, prev_l, prev_rst;
    logic [31:0] prev_d;

    adsb_demodulator #(
        .AXI_DATA_WIDTH (32),
        .IQ_WIDTH       (14)
    ) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .Adc_valid    (Adc_valid),
        .Adc_data_i   (Adc_data_i),
        .Adc_data_q   (Adc_data_q),
        .S_axis_ready (S_axis_ready),
        .S_axis_valid (S_axis_valid),
        .S_axis_data  (S_axis_data),
        .S_axis_last  (S_axis_last),
        .M_axis_ready (M_axis_ready),
        .M_axis_valid (M_axis_valid),
        .M_axis_data  (M_axis_data),
        .M_axis_last  (M_axis_last)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic cfg_beat(input logic [31:0] d, input logic l);
        S_axis_valid = 1'b1;
        S_axis_data  = d;
        S_axis_last  = l;
        tick();
        S_axis_valid = 1'b0;
        S_axis_last  = 1'b0;
    endtask

    task automatic configure(input logic [15:0] thr);
        cfg_beat(32'hAD5B0101, 1'b0);
        cfg_beat({16'h0000, thr}, 1'b1);
        tick();
    endtask

    task automatic sample(input int i, input int q);
        Adc_valid  = 1'b1;
        Adc_data_i = 14'(i);
        Adc_data_q = 14'(q);
        tick();
        Adc_valid  = 1'b0;
        sample_cnt++;
    endtask

    task automatic zeros(input int n);
        for (int k = 0; k < n; k++) sample(0, 0);
    endtask

    task automatic send_frame(input int amp, input logic [111:0] msg, input bit expect_rep,
                              input int nbits);
        logic [31:0] ts;
        ts = 32'(sample_cnt);
        if (expect_rep) begin
            sb.push_back({1'b0, 32'hAD5B0102});
            sb.push_back({1'b0, ts});
            sb.push_back({1'b0, msg[111:80]});
            sb.push_back({1'b0, msg[79:48]});
            sb.push_back({1'b0, msg[47:16]});
            sb.push_back({1'b1, msg[15:0], 16'h0000});
        end
        for (int p = 0; p < 16; p++) begin
            if (p == 0 || p == 2 || p == 7 || p == 9) sample(amp, 0);
            else                                      sample(0, 0);
        end
        for (int b = 111; b > 111 - nbits; b--) begin
            if (msg[b]) begin sample(amp, 0); sample(0, 0);   end
            else        begin sample(0, 0);   sample(0, amp); end
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d report beats still outstanding, required 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic check_idle(input string name, input int cycles);
        for (int k = 0; k < cycles; k++) tick();
        n_cmp++;
        if (M_axis_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s: M_axis_valid=%b required 0", name, M_axis_valid);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_cmp++;
        if (M_axis_valid !== 1'b0 || M_axis_last !== 1'b0 || M_axis_data !== 32'h0
            || S_axis_ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s: valid=%b last=%b data=%h s_ready=%b required 0/0/00000000/0",
                     name, M_axis_valid, M_axis_last, M_axis_data, S_axis_ready);
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        Adc_valid = 1'b0; Adc_data_i = '0; Adc_data_q = '0;
        S_axis_valid = 1'b0; S_axis_data = '0; S_axis_last = 1'b0;
        M_axis_ready = 1'b1;
        #2;
        tick(); tick();
        check_reset_outputs("reset_values");
        Rst_n = 1'b1;
        sample_cnt = 0;
        tick();
        n_cmp++;
        if (S_axis_ready !== 1'b1) begin
            n_err++;
            $display("FAIL s_ready_after_reset: got %b required 1", S_axis_ready);
        end
    endtask

    task automatic test_config_min();
        configure(16'd1);
        n_cmp++;
        if (S_axis_ready !== 1'b1) begin
            n_err++;
            $display("FAIL s_ready_stays: got %b required 1", S_axis_ready);
        end
        zeros(40);
        check_idle("thr1_no_report", 10);
    endtask

    task automatic test_report();
        int k = 0;
        configure(16'd256);
        zeros(20);
        send_frame(1000, msg_a, 1'b1, 112);
        while (M_axis_valid !== 1'b1 && k < 8) begin
            tick();
            k++;
        end
        n_cmp++;
        if (M_axis_valid !== 1'b1 || k > 4) begin
            n_err++;
            $display("FAIL report_latency: valid=%b after %0d cycles, required 1 within 4", M_axis_valid, k);
        end
        wait_drain("report_a", 100);
        check_idle("report_a_done", 5);
    endtask

    task automatic test_weak_and_bad_cfg();
        zeros(10);
        send_frame(200, msg_a, 1'b0, 112);
        zeros(10);
        check_idle("weak_no_report", 5);
        cfg_beat(32'hAD5B0102, 1'b0);
        cfg_beat(32'h00000001, 1'b1);
        tick();
        zeros(10);
        send_frame(200, msg_a, 1'b0, 112);
        zeros(10);
        check_idle("bad_hdr_thr_kept", 5);
        send_frame(1000, msg_b, 1'b1, 112);
        zeros(4);
        wait_drain("after_bad_hdr", 100);
    endtask

    task automatic test_back_to_back();
        M_axis_ready = 1'b0;
        zeros(8);
        send_frame(1000, msg_a, 1'b1, 112);
        zeros(4);
        send_frame(1000, msg_b, 1'b0, 112);
        zeros(10);
        n_cmp++;
        if (M_axis_valid !== 1'b1 || M_axis_data !== 32'hAD5B0102) begin
            n_err++;
            $display("FAIL stalled_head: valid=%b data=%h required 1/ad5b0102", M_axis_valid, M_axis_data);
        end
        for (int k = 0; k < 400 && sb.size() != 0; k++) begin
            M_axis_ready = ($urandom_range(0, 99) < 80);
            tick();
        end
        M_axis_ready = 1'b1;
        wait_drain("back_to_back_first", 10);
        check_idle("back_to_back_second_dropped", 20);
    endtask

    task automatic test_noise();
        for (int n = 0; n < 10000; n++) begin
            sample(int'($urandom_range(0, 126)) - 63, int'($urandom_range(0, 126)) - 63);
            for (int g = int'($urandom_range(0, 5)); g > 0; g--) tick();
        end
        check_idle("noise_no_report", 5);
        zeros(20);
        send_frame(1000, msg_a, 1'b1, 112);
        zeros(4);
        wait_drain("noise_ts", 100);
    endtask

    task automatic test_reset_midway();
        int k = 0;
        zeros(5);
        send_frame(1000, msg_a, 1'b0, 25);
        Rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_in_data");
        tick();
        Rst_n = 1'b1;
        sample_cnt = 0;
        tick();
        zeros(5);
        send_frame(1000, msg_a, 1'b0, 112);
        zeros(5);
        check_idle("no_report_unconfigured", 5);
        configure(16'd256);
        M_axis_ready = 1'b0;
        zeros(5);
        send_frame(1000, msg_b, 1'b1, 112);
        while (M_axis_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        M_axis_ready = 1'b1;
        tick();
        tick();
        M_axis_ready = 1'b0;
        Rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_in_report");
        n_cmp++;
        if (sb.size() != 4) begin
            n_err++;
            $display("FAIL beats_before_reset: %0d beats outstanding, required 4", sb.size());
        end
        sb.delete();
        tick();
        Rst_n = 1'b1;
        M_axis_ready = 1'b1;
        sample_cnt = 0;
        tick();
        zeros(5);
        send_frame(1000, msg_b, 1'b0, 112);
        zeros(5);
        check_idle("no_report_after_reset", 5);
        configure(16'd256);
        zeros(3);
        send_frame(1000, msg_a, 1'b1, 112);
        zeros(4);
        wait_drain("report_after_reconfig", 100);
    endtask

    initial begin
        prev_v = 1'b0; prev_r = 1'b0; prev_l = 1'b0; prev_rst = 1'b0; prev_d = '0;
        fork
            forever begin
                @(negedge Clk);
                if (Rst_n === 1'b1 && prev_rst === 1'b1) begin
                    if (prev_v && !prev_r) begin
                        n_cmp++;
                        if (M_axis_valid !== 1'b1 || M_axis_data !== prev_d || M_axis_last !== prev_l) begin
                            n_err++;
                            $display("FAIL stall_hold: valid=%b data=%h last=%b required 1/%h/%b",
                                     M_axis_valid, M_axis_data, M_axis_last, prev_d, prev_l);
                        end
                    end
                    if (M_axis_valid === 1'b1 && M_axis_ready === 1'b1) begin
                        n_cmp++;
                        if (sb.size() == 0) begin
                            n_err++;
                            $display("FAIL unexpected_beat: got %h last=%b required no beat", M_axis_data, M_axis_last);
                        end else begin
                            logic [32:0] exp_beat;
                            exp_beat = sb.pop_front();
                            if ({M_axis_last, M_axis_data} !== exp_beat) begin
                                n_err++;
                                $display("FAIL report_beat: got last=%b data=%h required last=%b data=%h",
                                         M_axis_last, M_axis_data, exp_beat[32], exp_beat[31:0]);
                            end
                        end
                    end
                end
                prev_v   = M_axis_valid;
                prev_r   = M_axis_ready;
                prev_d   = M_axis_data;
                prev_l   = M_axis_last;
                prev_rst = Rst_n;
            end
        join_none

        test_reset();
        test_config_min();
        test_report();
        test_weak_and_bad_cfg();
        test_back_to_back();
        test_noise();
        test_reset_midway();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
